// File: rtl/zilla_lsu_agen_split_if.sv
// Data-memory port bundle between the load/store unit and the memory.
// Latency: none (wires only).
// Backpressure: request held by the LSU until mem_gnt_i; load data qualified by mem_rvalid_i.
interface zilla_lsu_agen_split_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int NB = DATA_WIDTH / 8;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [NB-1:0]         mem_be_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    // LSU side drives the request, memory side answers with grant/data.
    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/zilla_lsu_agen_split.sv
// Load/store address generator and sequencer; splits word-crossing accesses into two beats.
// Latency: aligned load resp 3 cycles after accept, store 2; each extra beat +2 (load) / +1 (store).
// Backpressure: req_ready_o only in IDLE; memory request held until grant, WAIT states hold until rvalid.
module zilla_lsu_agen_split #(
    parameter int DATA_WIDTH     = 32,
    parameter int GPR_ADDR_WIDTH = 5,
    parameter bit SPLIT_EN       = 1'b1
) (
    input  logic                      addr_clk,
    input  logic                      addr_rst,
    input  logic                      wdt_reset_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [11:0]               alu_ctrl,
    input  logic [1:0]                fwd_sel_i,
    input  logic [DATA_WIDTH-1:0]     rs1_data,
    input  logic [DATA_WIDTH-1:0]     alu_data,
    input  logic [DATA_WIDTH-1:0]     mem_wb_data,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic [DATA_WIDTH-1:0]     imm_val,
    input  logic [DATA_WIDTH-1:0]     st_data_i,
    input  logic [GPR_ADDR_WIDTH-1:0] rd_i,
    output logic [DATA_WIDTH-1:0]     agen_addr_o,
    zilla_lsu_agen_split_if.master    mem,
    output logic                      resp_valid_o,
    output logic [DATA_WIDTH-1:0]     ld_data_o,
    output logic [GPR_ADDR_WIDTH-1:0] rd_o,
    output logic                      misalign_exc_o,
    output logic                      illegal_exc_o,
    output logic [DATA_WIDTH-1:0]     exc_addr_o
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]     ea_q;
    logic [2:0]                f3_q;
    logic                      we_q;
    logic                      cross_q;
    logic [DATA_WIDTH-1:0]     st_q;
    logic [GPR_ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0]     rdat0_q;
    logic [DATA_WIDTH-1:0]     rdat1_q;
    logic                      misalign_q;
    logic                      illegal_q;
    logic [DATA_WIDTH-1:0]     exc_addr_q;

    logic [DATA_WIDTH-1:0]     operand_c;
    logic [DATA_WIDTH-1:0]     ea_c;
    logic [2:0]                f3_c;
    logic                      is_ld_c;
    logic                      is_st_c;
    logic                      illegal_c;
    logic [OW-1:0]             off_c;
    logic [3:0]                sz_c;
    logic [4:0]                end_c;
    logic                      cross_c;
    logic                      misalign_c;
    logic                      accept;
    logic                      go_c;

    // Operand forwarding mux and effective address.
    always_comb begin
        operand_c = rs1_data;
        case (fwd_sel_i)
            2'd0:    operand_c = rs1_data;
            2'd1:    operand_c = alu_data;
            2'd2:    operand_c = mem_wb_data;
            default: operand_c = wb_data;
        endcase
    end

    assign ea_c        = operand_c + imm_val;
    assign agen_addr_o = ea_c;

    // Opcode decode, legality and word-crossing detection for the incoming request.
    always_comb begin
        f3_c      = alu_ctrl[9:7];
        is_ld_c   = (alu_ctrl[6:0] == 7'b0000011);
        is_st_c   = (alu_ctrl[6:0] == 7'b0100011);
        illegal_c = (alu_ctrl[11:10] != 2'b00)
                  | !(is_ld_c | is_st_c)
                  | (f3_c == 3'b111)
                  | (is_st_c & f3_c[2])
                  | ((DATA_WIDTH == 32) && (f3_c[1:0] == 2'b11));
        off_c      = ea_c[OW-1:0];
        sz_c       = 4'd1 << f3_c[1:0];
        end_c      = 5'(off_c) + 5'(sz_c);
        cross_c    = (end_c > 5'(NB));
        misalign_c = cross_c && !SPLIT_EN && !illegal_c;
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign accept      = req_valid_i & req_ready_o;
    assign go_c        = accept & !illegal_c & !misalign_c;

    // Sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go_c) state_d = S_REQ0;
            S_REQ0:  if (mem.mem_gnt_i) begin
                         if (!we_q)        state_d = S_WAIT0;
                         else if (cross_q) state_d = S_REQ1;
                         else              state_d = S_DONE;
                     end
            S_WAIT0: if (mem.mem_rvalid_i) state_d = cross_q ? S_REQ1 : S_DONE;
            S_REQ1:  if (mem.mem_gnt_i)    state_d = we_q ? S_DONE : S_WAIT1;
            S_WAIT1: if (mem.mem_rvalid_i) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; watchdog clear drops any in-flight access.
    always_ff @(posedge addr_clk or negedge addr_rst) begin
        if (!addr_rst) begin
            state_q <= S_IDLE;
        end else if (wdt_reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture, load beat capture and exception pulses.
    always_ff @(posedge addr_clk or negedge addr_rst) begin
        if (!addr_rst) begin
            ea_q       <= '0;
            f3_q       <= '0;
            we_q       <= 1'b0;
            cross_q    <= 1'b0;
            st_q       <= '0;
            rd_q       <= '0;
            rdat0_q    <= '0;
            rdat1_q    <= '0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
            exc_addr_q <= '0;
        end else if (wdt_reset_i) begin
            ea_q       <= '0;
            f3_q       <= '0;
            we_q       <= 1'b0;
            cross_q    <= 1'b0;
            st_q       <= '0;
            rd_q       <= '0;
            rdat0_q    <= '0;
            rdat1_q    <= '0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
            exc_addr_q <= '0;
        end else begin
            misalign_q <= accept & misalign_c;
            illegal_q  <= accept & illegal_c;
            if (accept & (illegal_c | misalign_c)) begin
                exc_addr_q <= ea_c;
            end
            if (go_c) begin
                ea_q    <= ea_c;
                f3_q    <= f3_c;
                we_q    <= is_st_c;
                cross_q <= cross_c;
                st_q    <= st_data_i;
                rd_q    <= rd_i;
            end
            if ((state_q == S_WAIT0) && mem.mem_rvalid_i) begin
                rdat0_q <= mem.mem_rdata_i;
            end
            if ((state_q == S_WAIT1) && mem.mem_rvalid_i) begin
                rdat1_q <= mem.mem_rdata_i;
            end
        end
    end

    logic [OW-1:0]             off_q;
    logic [3:0]                sz_q;
    logic [2*NB-1:0]           be_base;
    logic [2*NB-1:0]           be_wide;
    logic [2*DATA_WIDTH-1:0]   wd_wide;
    logic [DATA_WIDTH-1:0]     base_addr;
    logic                      beat1;

    assign off_q = ea_q[OW-1:0];
    assign sz_q  = 4'd1 << f3_q[1:0];

    // Beat lane mapping: a double-width mask/data window split across the two words.
    always_comb begin
        be_base = '0;
        for (int i = 0; i < 2 * NB; i++) begin
            be_base[i] = (i < int'(sz_q));
        end
        be_wide   = be_base << off_q;
        wd_wide   = {{DATA_WIDTH{1'b0}}, st_q} << {off_q, 3'b000};
        base_addr = {ea_q[DATA_WIDTH-1:OW], {OW{1'b0}}};
        beat1     = (state_q == S_REQ1) || (state_q == S_WAIT1);
    end

    assign mem.mem_req_o   = (state_q == S_REQ0) || (state_q == S_REQ1);
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = beat1 ? (base_addr + DATA_WIDTH'(NB)) : base_addr;
    assign mem.mem_be_o    = beat1 ? be_wide[2*NB-1:NB] : be_wide[NB-1:0];
    assign mem.mem_wdata_o = beat1 ? wd_wide[2*DATA_WIDTH-1:DATA_WIDTH] : wd_wide[DATA_WIDTH-1:0];

    logic [2*DATA_WIDTH-1:0] ld_wide;
    logic [DATA_WIDTH-1:0]   ld_raw;
    logic [DATA_WIDTH-1:0]   ld_ext;
    logic                    sgn;
    logic                    fill;

    // Load assembly: shift the two beats down by the offset, then extend above sz bytes.
    always_comb begin
        ld_wide = {rdat1_q, rdat0_q} >> {off_q, 3'b000};
        ld_raw  = ld_wide[DATA_WIDTH-1:0];
        sgn     = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (k == int'(sz_q) - 1) sgn = ld_raw[8*k+7];
        end
        fill   = (!f3_q[2] && (int'(sz_q) < NB)) ? sgn : 1'b0;
        ld_ext = '0;
        for (int k = 0; k < NB; k++) begin
            ld_ext[8*k +: 8] = (k < int'(sz_q)) ? ld_raw[8*k +: 8] : {8{fill}};
        end
    end

    assign resp_valid_o   = (state_q == S_DONE);
    assign ld_data_o      = ld_ext;
    assign rd_o           = rd_q;
    assign misalign_exc_o = misalign_q;
    assign illegal_exc_o  = illegal_q;
    assign exc_addr_o     = exc_addr_q;

endmodule

// File: tb/tb_zilla_lsu_agen_split.sv
// Directed bench for the load/store address generator, split and non-split builds side by side.
// Latency: checks exact response cycle for aligned, split and faulting accesses.
// Backpressure: memory grant/rvalid are driven by hand each cycle.
module tb_zilla_lsu_agen_split;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wdt;
    logic        req_a, req_b;
    logic [11:0] alu_ctrl;
    logic [1:0]  fwd_sel;
    logic [31:0] rs1_data, alu_data, mem_wb_data, wb_data, imm_val, st_data;
    logic [4:0]  rd_in;

    logic        rdy_a, rdy_b, resp_a, resp_b, mis_a, mis_b, ill_a, ill_b;
    logic [31:0] agen_a, agen_b, ld_a, ld_b, exc_a, exc_b;
    logic [4:0]  rd_a, rd_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    zilla_lsu_agen_split_if #(.DATA_WIDTH(32)) mif();
    zilla_lsu_agen_split_if #(.DATA_WIDTH(32)) mif_ns();

    zilla_lsu_agen_split #(.DATA_WIDTH(32), .GPR_ADDR_WIDTH(5), .SPLIT_EN(1'b1)) dut (
        .addr_clk(clk), .addr_rst(rst_n), .wdt_reset_i(wdt),
        .req_valid_i(req_a), .req_ready_o(rdy_a), .alu_ctrl(alu_ctrl), .fwd_sel_i(fwd_sel),
        .rs1_data(rs1_data), .alu_data(alu_data), .mem_wb_data(mem_wb_data), .wb_data(wb_data),
        .imm_val(imm_val), .st_data_i(st_data), .rd_i(rd_in), .agen_addr_o(agen_a),
        .mem(mif.master), .resp_valid_o(resp_a), .ld_data_o(ld_a), .rd_o(rd_a),
        .misalign_exc_o(mis_a), .illegal_exc_o(ill_a), .exc_addr_o(exc_a)
    );

    zilla_lsu_agen_split #(.DATA_WIDTH(32), .GPR_ADDR_WIDTH(5), .SPLIT_EN(1'b0)) dut_ns (
        .addr_clk(clk), .addr_rst(rst_n), .wdt_reset_i(wdt),
        .req_valid_i(req_b), .req_ready_o(rdy_b), .alu_ctrl(alu_ctrl), .fwd_sel_i(fwd_sel),
        .rs1_data(rs1_data), .alu_data(alu_data), .mem_wb_data(mem_wb_data), .wb_data(wb_data),
        .imm_val(imm_val), .st_data_i(st_data), .rd_i(rd_in), .agen_addr_o(agen_b),
        .mem(mif_ns.master), .resp_valid_o(resp_b), .ld_data_o(ld_b), .rd_o(rd_b),
        .misalign_exc_o(mis_b), .illegal_exc_o(ill_b), .exc_addr_o(exc_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] op_ld(input logic [2:0] f3);
        return {2'b00, f3, 7'b0000011};
    endfunction

    function automatic logic [11:0] op_st(input logic [2:0] f3);
        return {2'b00, f3, 7'b0100011};
    endfunction

    // Present one request for one cycle (called at a negedge); returns at the T1 negedge.
    task automatic issue(input logic [11:0] ctrl, input logic [31:0] base, input logic [31:0] imm,
                         input logic [31:0] sd, input logic [4:0] rd, input bit on_ns);
        alu_ctrl = ctrl; fwd_sel = 2'd0; rs1_data = base; imm_val = imm; st_data = sd; rd_in = rd;
        if (on_ns) req_b = 1'b1; else req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wdt = 1'b0; req_a = 1'b0; req_b = 1'b0;
        alu_ctrl = '0; fwd_sel = '0; rs1_data = '0; alu_data = '0; mem_wb_data = '0; wb_data = '0;
        imm_val = '0; st_data = '0; rd_in = '0;
        mif.mem_gnt_i = 1'b0; mif.mem_rvalid_i = 1'b0; mif.mem_rdata_i = '0;
        mif_ns.mem_gnt_i = 1'b0; mif_ns.mem_rvalid_i = 1'b0; mif_ns.mem_rdata_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_req", mif.mem_req_o, 1'b0);
        chk("rst_resp", resp_a, 1'b0);
        chk("rst_exc", {mis_a, ill_a, mis_b, ill_b}, 4'b0000);
        chk("rst_exc_addr", exc_a, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {rdy_a, rdy_b}, 2'b11);

        // 1: lw rs1=0x1000 imm=4, zero-wait
        alu_ctrl = op_ld(3'b010); rs1_data = 32'h1000; imm_val = 32'h4; #1;
        chk("t1_agen", agen_a, 32'h1004);
        issue(op_ld(3'b010), 32'h1000, 32'h4, 32'h0, 5'd5, 1'b0);
        chk("t1_req", {mif.mem_req_o, mif.mem_we_o}, 2'b10);
        chk("t1_addr", mif.mem_addr_o, 32'h1004);
        chk("t1_be", mif.mem_be_o, 4'b1111);
        chk("t1_ready_busy", rdy_a, 1'b0);
        mif.mem_gnt_i = 1'b1;
        @(negedge clk);
        mif.mem_gnt_i = 1'b0; mif.mem_rvalid_i = 1'b1; mif.mem_rdata_i = 32'h80000001;
        chk("t1_req_t2", mif.mem_req_o, 1'b0);
        chk("t1_resp_t2", resp_a, 1'b0);
        @(negedge clk);
        mif.mem_rvalid_i = 1'b0;
        chk("t1_resp_t3", resp_a, 1'b1);
        chk("t1_ld", ld_a, 32'h80000001);
        chk("t1_rd", rd_a, 5'd5);
        @(negedge clk);
        chk("t1_resp_t4", resp_a, 1'b0);
        chk("t1_ready_t4", rdy_a, 1'b1);

        // 2: lb / lbu at 0x1003
        issue(op_ld(3'b000), 32'h1000, 32'h3, 32'h0, 5'd6, 1'b0);
        chk("t2_addr", mif.mem_addr_o, 32'h1000);
        chk("t2_be", mif.mem_be_o, 4'b1000);
        mif.mem_gnt_i = 1'b1;
        @(negedge clk);
        mif.mem_gnt_i = 1'b0; mif.mem_rvalid_i = 1'b1; mif.mem_rdata_i = 32'h80000000;
        @(negedge clk);
        mif.mem_rvalid_i = 1'b0;
        chk("t2_lb", ld_a, 32'hFFFFFF80);
        @(negedge clk);
        issue(op_ld(3'b100), 32'h1000, 32'h3, 32'h0, 5'd6, 1'b0);
        mif.mem_gnt_i = 1'b1;
        @(negedge clk);
        mif.mem_gnt_i = 1'b0; mif.mem_rvalid_i = 1'b1; mif.mem_rdata_i = 32'h80000000;
        @(negedge clk);
        mif.mem_rvalid_i = 1'b0;
        chk("t2_lbu_resp", resp_a, 1'b1);
        chk("t2_lbu", ld_a, 32'h00000080);
        @(negedge clk);

        // 3: split sw at 0x1002
        issue(op_st(3'b010), 32'h1000, 32'h2, 32'hAABBCCDD, 5'd0, 1'b0);
        chk("t3_b0_req", {mif.mem_req_o, mif.mem_we_o}, 2'b11);
        chk("t3_b0_addr", mif.mem_addr_o, 32'h1000);
        chk("t3_b0_be", mif.mem_be_o, 4'b1100);
        chk("t3_b0_wd", mif.mem_wdata_o, 32'hCCDD0000);
        mif.mem_gnt_i = 1'b1;
        @(negedge clk);
        chk("t3_b1_req", mif.mem_req_o, 1'b1);
        chk("t3_b1_addr", mif.mem_addr_o, 32'h1004);
        chk("t3_b1_be", mif.mem_be_o, 4'b0011);
        chk("t3_b1_wd", mif.mem_wdata_o, 32'h0000AABB);
        chk("t3_resp_t2", resp_a, 1'b0);
        @(negedge clk);
        mif.mem_gnt_i = 1'b0;
        chk("t3_resp_t3", resp_a, 1'b1);
        chk("t3_req_t3", mif.mem_req_o, 1'b0);
        @(negedge clk);

        // 4: split lh at 0x1003, positive then negative high byte
        for (int pass = 0; pass < 2; pass++) begin
            issue(op_ld(3'b001), 32'h1000, 32'h3, 32'h0, 5'd9, 1'b0);
            chk("t4_b0_be", mif.mem_be_o, 4'b1000);
            mif.mem_gnt_i = 1'b1;
            @(negedge clk);
            mif.mem_gnt_i = 1'b0; mif.mem_rvalid_i = 1'b1; mif.mem_rdata_i = 32'h12000000;
            @(negedge clk);
            mif.mem_rvalid_i = 1'b0;
            chk("t4_b1_req", mif.mem_req_o, 1'b1);
            chk("t4_b1_addr", mif.mem_addr_o, 32'h1004);
            chk("t4_b1_be", mif.mem_be_o, 4'b0001);
            mif.mem_gnt_i = 1'b1;
            @(negedge clk);
            mif.mem_gnt_i = 1'b0; mif.mem_rvalid_i = 1'b1;
            mif.mem_rdata_i = (pass == 0) ? 32'h00000034 : 32'h000000F4;
            chk("t4_resp_t4", resp_a, 1'b0);
            @(negedge clk);
            mif.mem_rvalid_i = 1'b0;
            chk("t4_resp_t5", resp_a, 1'b1);
            chk("t4_ld", ld_a, (pass == 0) ? 32'h00003412 : 32'hFFFFF412);
            @(negedge clk);
        end

        // 5: non-split build: crossing sw faults, in-word lh at 0x1001 is one beat
        issue(op_st(3'b010), 32'h1000, 32'h2, 32'hAABBCCDD, 5'd0, 1'b1);
        chk("t5_mis_pulse", mis_b, 1'b1);
        chk("t5_exc_addr", exc_b, 32'h1002);
        chk("t5_no_req", mif_ns.mem_req_o, 1'b0);
        chk("t5_ready", rdy_b, 1'b1);
        @(negedge clk);
        chk("t5_mis_end", mis_b, 1'b0);
        chk("t5_no_req2", mif_ns.mem_req_o, 1'b0);
        chk("t5_exc_hold", exc_b, 32'h1002);
        issue(op_ld(3'b001), 32'h1000, 32'h1, 32'h0, 5'd3, 1'b1);
        chk("t5_lh_mis", mis_b, 1'b0);
        chk("t5_lh_be", mif_ns.mem_be_o, 4'b0110);
        mif_ns.mem_gnt_i = 1'b1;
        @(negedge clk);
        mif_ns.mem_gnt_i = 1'b0; mif_ns.mem_rvalid_i = 1'b1; mif_ns.mem_rdata_i = 32'h00ABCD00;
        @(negedge clk);
        mif_ns.mem_rvalid_i = 1'b0;
        chk("t5_lh_resp", resp_b, 1'b1);
        chk("t5_lh_ld", ld_b, 32'hFFFFABCD);
        @(negedge clk);
        issue(op_ld(3'b111), 32'h2000, 32'h0, 32'h0, 5'd1, 1'b0);
        chk("t5_ill_pulse", ill_a, 1'b1);
        chk("t5_ill_addr", exc_a, 32'h2000);
        chk("t5_ill_noreq", mif.mem_req_o, 1'b0);
        @(negedge clk);
        chk("t5_ill_end", ill_a, 1'b0);
        issue(op_st(3'b100), 32'h3000, 32'h0, 32'h0, 5'd1, 1'b0);
        chk("t5_ill_st", {ill_a, mif.mem_req_o}, 2'b10);
        @(negedge clk);

        // 6: forwarding sources, then watchdog clear during WAIT1
        fwd_sel = 2'd2; mem_wb_data = 32'h0; imm_val = 32'hFFFFFFFC; alu_data = 32'h10; wb_data = 32'h20; #1;
        chk("t6_fwd2", agen_a, 32'hFFFFFFFC);
        fwd_sel = 2'd1; #1;
        chk("t6_fwd1", agen_a, 32'h0000000C);
        fwd_sel = 2'd3; #1;
        chk("t6_fwd3", agen_a, 32'h0000001C);
        @(negedge clk);
        alu_ctrl = op_ld(3'b010); fwd_sel = 2'd2; mem_wb_data = 32'h0; imm_val = 32'hFFFFFFFE;
        rd_in = 5'd7; req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        chk("t6_b0_addr", mif.mem_addr_o, 32'hFFFFFFFC);
        chk("t6_b0_be", mif.mem_be_o, 4'b1100);
        mif.mem_gnt_i = 1'b1;
        @(negedge clk);
        mif.mem_gnt_i = 1'b0; mif.mem_rvalid_i = 1'b1; mif.mem_rdata_i = 32'h11223344;
        @(negedge clk);
        mif.mem_rvalid_i = 1'b0;
        chk("t6_b1_addr", mif.mem_addr_o, 32'h00000000);
        chk("t6_b1_be", mif.mem_be_o, 4'b0011);
        mif.mem_gnt_i = 1'b1;
        @(negedge clk);
        mif.mem_gnt_i = 1'b0;
        chk("t6_wait1_busy", {rdy_a, mif.mem_req_o}, 2'b00);
        wdt = 1'b1;
        @(negedge clk);
        wdt = 1'b0;
        chk("t6_wdt_ready", rdy_a, 1'b1);
        chk("t6_wdt_noresp", resp_a, 1'b0);
        mif.mem_rvalid_i = 1'b1; mif.mem_rdata_i = 32'hDEADBEEF;
        @(negedge clk);
        mif.mem_rvalid_i = 1'b0;
        chk("t6_stray_rvalid", {resp_a, rdy_a}, 2'b01);
        @(negedge clk);
        chk("t6_idle_end", {resp_a, mif.mem_req_o}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/zilla_lsu_agen_split.md
Name: zilla_lsu_agen_split

Overview:
Parametrised load/store address generator and memory sequencer, one per core, sitting between the EX stage and the data-memory port.
- Selects the rs1 operand from the forwarding sources and adds the immediate to form the effective address.
- Decodes the load/store opcode into size, sign and direction.
- Issues a valid/grant handshake to data memory.
- When an access crosses a DATA_WIDTH word boundary, splits it into two aligned beats (or raises a misalign exception when splitting is disabled).
- Returns a sign- or zero-extended load result.

Parameters:
DATA_WIDTH, 32, datapath/address width; legal values 32 and 64. NB = DATA_WIDTH/8.
GPR_ADDR_WIDTH, 5, register index width (carried through on rd tag).
SPLIT_EN, 1, 1 = split word-crossing accesses into two beats; 0 = raise misalign_exc_o.

Ports:
addr_clk  in  1  clock
addr_rst  in  1  asynchronous active-low reset
wdt_reset_i  in  1  synchronous clear, same effect as reset
req_valid_i  in  1  load/store request from EX
req_ready_o  out  1  =1 only in IDLE
alu_ctrl  in  12  [6:0] opcode (0000011 load, 0100011 store), [9:7] funct3, [11:10] must be 0
fwd_sel_i  in  2  operand source: 0 rs1_data, 1 alu_data, 2 mem_wb_data, 3 wb_data
rs1_data, alu_data, mem_wb_data, wb_data  in  DATA_WIDTH  operand sources
imm_val  in  DATA_WIDTH  sign-extended immediate
st_data_i  in  DATA_WIDTH  store data, LSB-aligned
rd_i  in  GPR_ADDR_WIDTH  load destination tag
agen_addr_o  out  DATA_WIDTH  combinational effective address (operand + imm)
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = store
mem_addr_o  out  DATA_WIDTH  word-aligned address (low log2(NB) bits 0)
mem_be_o  out  NB  byte enables
mem_wdata_o  out  DATA_WIDTH  lane-shifted store data
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  load beat data valid
mem_rdata_i  in  DATA_WIDTH  load beat data
resp_valid_o  out  1  one-cycle completion pulse (load or store)
ld_data_o  out  DATA_WIDTH  extended load result, valid with resp_valid_o on loads
rd_o  out  GPR_ADDR_WIDTH  tag returned with resp_valid_o
misalign_exc_o  out  1  one-cycle pulse
illegal_exc_o  out  1  one-cycle pulse
exc_addr_o  out  DATA_WIDTH  faulting effective address, held until next exception

Behaviour:
- Reset (addr_rst low, async) or wdt_reset_i (sync): state IDLE, all registered outputs 0, req_ready_o=1 once released. Any in-flight transaction is dropped and no response is given.
- Accept: req_valid_i & req_ready_o. Latch ea = operand + imm_val (mod 2^DATA_WIDTH), funct3, direction, st_data_i, rd_i.
- Size: sz = 1 << funct3[1:0]. Byte offset: off = ea mod NB.
- Illegal cases (decided at accept; next cycle illegal_exc_o=1, exc_addr_o=ea, return to IDLE, no mem_req):
  - funct3=111;
  - store with funct3[2]=1;
  - DATA_WIDTH=32 and funct3[1:0]=11;
  - alu_ctrl matches neither load nor store opcode.
- Crossing rule: cross = (off + sz > NB). Sub-word misalignment inside one word is a single beat.
  - If cross and SPLIT_EN=0: next cycle misalign_exc_o=1, exc_addr_o=ea, no mem_req.
- FSM: IDLE -> REQ0 -> (load) WAIT0 -> [cross] REQ1 -> (load) WAIT1 -> DONE -> IDLE.
  - Stores skip the WAIT states.
  - mem_req_o=1 only in REQ0/REQ1. Address, be, wdata and we are held stable until mem_gnt_i.
  - WAIT states hold until mem_rvalid_i.
  - DONE drives resp_valid_o=1 for exactly one cycle.
- Beat0: mem_addr_o = ea with low bits cleared; mem_be_o = ((1<<sz)-1) << off, truncated to NB bits; mem_wdata_o = st_data << 8*off.
- Beat1: mem_addr_o = beat0 address + NB; mem_be_o = ((1<<sz)-1) >> (NB-off); mem_wdata_o = st_data >> 8*(NB-off).
- Load assembly:
  - Beat0 bytes off..NB-1 go to result bytes 0..NB-1-off.
  - Beat1 bytes 0..(off+sz-NB-1) go to the following result bytes.
  - The result is then sign-extended from byte sz-1 if funct3[2]=0 and sz<NB, else zero-extended.
- Minimum latency (zero-wait memory: gnt in request cycle, rvalid next cycle), accept at T0:
  - Aligned load: resp at T3.
  - Aligned store: resp at T2.
  - Each split beat adds 2 cycles (load) or 1 cycle (store).
- A grant in the same cycle as reset is ignored. mem_rvalid_i outside WAIT states is ignored.

Test Plan:
1. DATA_WIDTH=32, lw, rs1=0x1000, imm=0x4, zero-wait, rdata 0x80000001 -> mem_addr 0x1004, be 1111, resp_valid at T3, ld_data 0x80000001.
2. lb at ea 0x1003, rdata 0x80000000 -> be 1000, ld_data 0xFFFFFF80; lbu same access -> 0x00000080.
3. sw at 0x1002, data 0xAABBCCDD -> beat0 addr 0x1000, be 1100, wdata 0xCCDD0000; beat1 addr 0x1004, be 0011, wdata 0x0000AABB; resp at T3.
4. lh at 0x1003, beat0 rdata 0x12000000, beat1 rdata 0x00000034 -> ld_data 0x00003412; with beat1 rdata 0x000000F4 -> 0xFFFFF412.
5. SPLIT_EN=0, sw at 0x1002 -> misalign_exc_o pulse at T1, exc_addr_o 0x1002, mem_req_o never asserted. funct3=111 -> illegal_exc_o pulse.
6. fwd_sel_i=2, mem_wb_data 0x0, imm 0xFFFFFFFC -> addr 0xFFFFFFFC. Then assert wdt_reset_i during WAIT1 -> next cycle IDLE, req_ready_o=1, no resp_valid_o.
